// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, types and helpers for the instruction-fetch
// front end.
//   FETCH_ADDR_W / FETCH_INSTR_W : default PC and halfword widths
//   FETCH_IMM_CLASS              : top-3-bit opcode class of two-halfword instructions
//   fetch_entry_t                : queue entry layout {instr, pc}
//   is_imm_instr()               : true when a halfword starts a two-halfword instruction
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 32;
  localparam int FETCH_INSTR_W = 16;

  localparam logic [2:0] FETCH_IMM_CLASS = 3'b001;

  // Queue entry: the halfword and the PC it was fetched from.
  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Opcode class lives in the three most significant bits of the halfword.
  function automatic logic is_imm_instr(input logic [FETCH_INSTR_W-1:0] hw,
                                        input logic [2:0] imm_class = FETCH_IMM_CLASS);
    return (hw[FETCH_INSTR_W-1 -: 3] == imm_class);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry show-ahead FIFO for the prefetch queue.
//   clk, rst      : clock, asynchronous active-low reset
//   flush         : synchronous empty (contents kept, pointers cleared)
//   push, wdata   : write 0/1 entry per cycle
//   pop_cnt       : remove 0, 1 or 2 entries from the head per cycle
//   head, head_nx : entry at the head and the entry behind it (registered)
//   count         : number of valid entries
module fetch_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic [1:0]                 pop_cnt,
  output logic [W-1:0]               head,
  output logic [W-1:0]               head_nx,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] rd_r;
  logic [PW-1:0] wr_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] rd_p1_s;

  assign rd_p1_s = rd_r + PW'(1);
  assign head    = mem_r[rd_r];
  assign head_nx = mem_r[rd_p1_s];
  assign count   = count_r;

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_r    <= {PW{1'b0}};
      wr_r    <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (flush) begin
      rd_r    <= {PW{1'b0}};
      wr_r    <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_r] <= wdata;
        wr_r        <= wr_r + PW'(1);
      end
      rd_r    <= rd_r + PW'(pop_cnt);
      count_r <= count_r + CW'(push) - CW'(pop_cnt);
    end
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction-fetch front end with a DEPTH-entry
// prefetch queue, immediate-halfword fusion, redirect and interrupt flush.
//   clk, rst                      : clock, asynchronous active-low reset
//   imem_req/addr/gnt             : fetch request channel (halfword addresses)
//   imem_rvalid/rdata             : in-order response channel, latency >= 1
//   redirect_valid/pc             : taken jump/branch, flushes the queue
//   irq_req / irq_ack / irq_epc   : interrupt request, entry pulse, return PC
//   out_valid/ready, out_*        : one instruction per cycle towards decode
// Build option: define FETCH_IRQ_EN to include the interrupt-entry logic;
// without it irq_req is ignored and irq_ack/irq_epc are tied to zero.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = FETCH_ADDR_W,
  parameter int                INSTR_W    = FETCH_INSTR_W,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0] IRQ_VECTOR = {ADDR_W{1'b0}},
  parameter logic [2:0]        IMM_CLASS  = FETCH_IMM_CLASS
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               irq_req,
  output logic               irq_ack,
  output logic [ADDR_W-1:0]  irq_epc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [INSTR_W-1:0] out_imm,
  output logic               out_has_imm,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_next_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTR_W + ADDR_W;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0]  fetch_pc_r, fetch_pc_nxt_s;
  logic [ADDR_W-1:0]  push_pc_r, push_pc_nxt_s;
  logic [CW-1:0]      outstanding_r, outstanding_nxt_s;
  logic [CW-1:0]      discard_r, discard_nxt_s;
  logic               run_r;

  logic               flush_s;
  logic               irq_entry_s;
  logic [ADDR_W-1:0]  flush_target_s;
  logic               gnt_s;
  logic               push_s;
  logic               issue_s;
  logic [1:0]         pop_cnt_s;
  logic [CW:0]        inflight_s;

  logic [CW-1:0]      count_s;
  logic [EW-1:0]      head_s, head_nx_s;
  logic [INSTR_W-1:0] head_instr_s, nx_instr_s;
  logic [ADDR_W-1:0]  head_pc_s;
  logic [FETCH_INSTR_W-1:0] head_cls_s;
  logic               head_imm_s, head_ok_s;
  logic               unused_nx_pc_s;

  // Queue entries are packed {instr, pc}, the same layout as fetch_entry_t.
  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_s),
    .push    (push_s),
    .wdata   ({imem_rdata, push_pc_r}),
    .pop_cnt (pop_cnt_s),
    .head    (head_s),
    .head_nx (head_nx_s),
    .count   (count_s)
  );

  assign head_instr_s   = head_s[EW-1 -: INSTR_W];
  assign head_pc_s      = head_s[ADDR_W-1:0];
  assign nx_instr_s     = head_nx_s[EW-1 -: INSTR_W];
  assign unused_nx_pc_s = ^head_nx_s[ADDR_W-1:0];

  // Only the class field matters, so align it into a package-width halfword.
  assign head_cls_s = {head_instr_s[INSTR_W-1 -: 3], {(FETCH_INSTR_W-3){1'b0}}};
  assign head_imm_s = is_imm_instr(head_cls_s, IMM_CLASS);

  // An immediate-carrying head waits until its immediate halfword is queued too.
  assign head_ok_s = (count_s >= CW'(2)) || ((count_s == CW'(1)) && !head_imm_s);

`ifdef FETCH_IRQ_EN
  logic irq_pending_r;

  // Interrupt request latch; a redirect in the same cycle defers entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_pending_r <= 1'b0;
    end else begin
      irq_pending_r <= (irq_pending_r && !irq_entry_s) || irq_req;
    end
  end

  assign irq_entry_s = irq_pending_r && !redirect_valid;
  assign irq_ack     = irq_entry_s;
  // Return to the oldest queued instruction, or to the fetch PC when empty.
  assign irq_epc     = !irq_entry_s ? {ADDR_W{1'b0}} :
                       (count_s != {CW{1'b0}}) ? head_pc_s : fetch_pc_r;
`else
  logic unused_irq_s;
  assign unused_irq_s = irq_req ^ (^IRQ_VECTOR);
  assign irq_entry_s  = 1'b0;
  assign irq_ack      = 1'b0;
  assign irq_epc      = {ADDR_W{1'b0}};
`endif

  assign flush_s        = redirect_valid || irq_entry_s;
  assign flush_target_s = redirect_valid ? redirect_pc : IRQ_VECTOR;

  // Request throttling counts in-flight and queued halfwords against DEPTH.
  assign inflight_s = {1'b0, outstanding_r} + {1'b0, count_s};
  assign imem_req   = run_r && (inflight_s < DEPTH_V) && !flush_s;
  assign imem_addr  = fetch_pc_r;
  assign gnt_s      = imem_req && imem_gnt;
  assign push_s     = imem_rvalid && (discard_r == {CW{1'b0}}) && !flush_s;

  assign out_valid   = head_ok_s && !flush_s;
  assign issue_s     = out_valid && out_ready;
  assign pop_cnt_s   = !issue_s ? 2'd0 : (head_imm_s ? 2'd2 : 2'd1);

  // Outputs read zero whenever no instruction is offered, so a flushed head never leaks.
  assign out_has_imm = out_valid && head_imm_s;
  assign out_instr   = out_valid   ? head_instr_s : {INSTR_W{1'b0}};
  assign out_imm     = out_has_imm ? nx_instr_s   : {INSTR_W{1'b0}};
  assign out_pc      = out_valid   ? head_pc_s    : {ADDR_W{1'b0}};
  assign out_next_pc = out_pc + ADDR_W'(1) + ADDR_W'(out_has_imm);

  // Next-state for fetch PC, push PC and the response bookkeeping counters.
  always_comb begin
    fetch_pc_nxt_s    = fetch_pc_r;
    push_pc_nxt_s     = push_pc_r;
    outstanding_nxt_s = outstanding_r;
    discard_nxt_s     = discard_r;
    if (flush_s) begin
      // Every response still in flight after this cycle belongs to the old stream.
      fetch_pc_nxt_s    = flush_target_s;
      push_pc_nxt_s     = flush_target_s;
      outstanding_nxt_s = outstanding_r - CW'(imem_rvalid);
      discard_nxt_s     = outstanding_r - CW'(imem_rvalid);
    end else begin
      if (gnt_s) begin
        fetch_pc_nxt_s = fetch_pc_r + ADDR_W'(1);
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      if (push_s) begin
        push_pc_nxt_s = push_pc_r + ADDR_W'(1);
      end else begin
        push_pc_nxt_s = push_pc_r;
      end
      outstanding_nxt_s = outstanding_r + CW'(gnt_s) - CW'(imem_rvalid);
      if (imem_rvalid && (discard_r != {CW{1'b0}})) begin
        discard_nxt_s = discard_r - CW'(1);
      end else begin
        discard_nxt_s = discard_r;
      end
    end
  end

  // Fetch state registers; run_r keeps imem_req low while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_r    <= RESET_PC;
      push_pc_r     <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      discard_r     <= {CW{1'b0}};
      run_r         <= 1'b0;
    end else begin
      fetch_pc_r    <= fetch_pc_nxt_s;
      push_pc_r     <= push_pc_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      discard_r     <= discard_nxt_s;
      run_r         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed bench for fetch_prefetch_queue with a
// small in-order instruction memory model of configurable latency.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        irq_req;
  logic        irq_ack;
  logic [31:0] irq_epc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_imm;
  logic        out_has_imm;
  logic [31:0] out_pc;
  logic [31:0] out_next_pc;

  fetch_prefetch_queue #(
    .ADDR_W(32), .INSTR_W(16), .DEPTH(4),
    .RESET_PC(32'h0000_0010), .IRQ_VECTOR(32'h0000_0080), .IMM_CLASS(3'b001)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .irq_req(irq_req), .irq_ack(irq_ack), .irq_epc(irq_epc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_imm(out_imm), .out_has_imm(out_has_imm), .out_pc(out_pc),
    .out_next_pc(out_next_pc)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] addr; } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [15:0] mem [0:255];
  pend_t       pend[$];
  logic [31:0] req_log[$];
  logic [31:0] acc_pc[$];
  logic [31:0] acc_next[$];
  logic [15:0] acc_instr[$];
  logic [15:0] acc_imm[$];
  logic        acc_has[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, log handshakes, advance to negedge.
  task automatic cycle();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem[pend[0].addr[7:0]];
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0000;
    end
    #1;
    if (imem_req && imem_gnt) begin
      pend.push_back('{due: cyc + lat, addr: imem_addr});
      req_log.push_back(imem_addr);
    end
    if (out_valid && out_ready) begin
      acc_pc.push_back(out_pc);
      acc_next.push_back(out_next_pc);
      acc_instr.push_back(out_instr);
      acc_imm.push_back(out_imm);
      acc_has.push_back(out_has_imm);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_logs();
    req_log.delete();
    acc_pc.delete(); acc_next.delete(); acc_instr.delete();
    acc_imm.delete(); acc_has.delete();
  endtask

  task automatic do_redirect(input string tag, input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    check({tag, "_req_low"}, imem_req, 1'b0);
    check({tag, "_valid_low"}, out_valid, 1'b0);
    cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_instr"}, out_instr, 16'h0000);
    check({tag, "_has_imm"}, out_has_imm, 1'b0);
    check({tag, "_pc"}, out_pc, 32'h0000_0000);
    check({tag, "_next_pc"}, out_next_pc, 32'h0000_0001);
    check({tag, "_irq_ack"}, irq_ack, 1'b0);
    check({tag, "_irq_epc"}, irq_epc, 32'h0000_0000);
  endtask

  logic        found;
  logic        have_snap;
  logic [15:0] snap_instr;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    redirect_valid = 1'b0; redirect_pc = 32'h0; irq_req = 1'b0; out_ready = 1'b1;

    // Reset state.
    @(negedge clk); #1;
    check_reset_outputs("rst");
    run(2);

    // Plain halfwords from RESET_PC with 1-cycle memory.
    mem[8'h10] = 16'h0001; mem[8'h11] = 16'h0002;
    rst = 1'b1;
    run(8);
    check("t1_nreq", req_log.size() >= 2, 1'b1);
    check("t1_addr0", req_log[0], 32'h10);
    check("t1_addr1", req_log[1], 32'h11);
    check("t1_nacc", acc_pc.size() >= 2, 1'b1);
    check("t1_instr0", acc_instr[0], 16'h0001);
    check("t1_pc0", acc_pc[0], 32'h10);
    check("t1_next0", acc_next[0], 32'h11);
    check("t1_instr1", acc_instr[1], 16'h0002);
    check("t1_pc1", acc_pc[1], 32'h11);

    // Immediate fusion: 0x3811 carries 0x0004, followed by plain 0x0005.
    mem[8'h00] = 16'h3811; mem[8'h01] = 16'h0004; mem[8'h02] = 16'h0005;
    clear_logs();
    do_redirect("t2", 32'h0);
    run(8);
    check("t2_nacc", acc_pc.size() >= 2, 1'b1);
    check("t2_instr0", acc_instr[0], 16'h3811);
    check("t2_has0", acc_has[0], 1'b1);
    check("t2_imm0", acc_imm[0], 16'h0004);
    check("t2_pc0", acc_pc[0], 32'h0);
    check("t2_next0", acc_next[0], 32'h2);
    check("t2_instr1", acc_instr[1], 16'h0005);
    check("t2_has1", acc_has[1], 1'b0);
    check("t2_imm1", acc_imm[1], 16'h0000);
    check("t2_pc1", acc_pc[1], 32'h2);
    check("t2_next1", acc_next[1], 32'h3);

    // Stall: queue fills to DEPTH, outputs hold, nothing lost on release.
    for (int i = 0; i < 16; i++) mem[8'h20 + i] = 16'h0100 + 16'(i);
    out_ready = 1'b0;
    clear_logs();
    do_redirect("t3", 32'h20);
    have_snap = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      #1;
      if (have_snap) begin
        check("t3_hold_instr", out_instr, 16'h0100);
        check("t3_hold_pc", out_pc, 32'h20);
      end else if (out_valid) begin
        have_snap = 1'b1;
        snap_instr = out_instr;
      end else begin
        have_snap = 1'b0;
      end
    end
    check("t3_snap", snap_instr, 16'h0100);
    check("t3_valid", out_valid, 1'b1);
    check("t3_req_low", imem_req, 1'b0);
    check("t3_nreq", req_log.size(), 32'd4);
    clear_logs();
    out_ready = 1'b1;
    run(10);
    check("t3_nacc", acc_pc.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("t3_seq_instr", acc_instr[i], 16'h0100 + 16'(i));
      check("t3_seq_pc", acc_pc[i], 32'h20 + 32'(i));
    end

    // 3-cycle memory: redirect with three responses in flight.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (pend.size() == 3) found = 1'b1;
    end
    check("t4_three_outstanding", found, 1'b1);
    for (int i = 0; i < 16; i++) mem[8'h40 + i] = 16'h0200 + 16'(i);
    clear_logs();
    do_redirect("t4", 32'h40);
    run(15);
    check("t4_nacc", acc_pc.size() >= 2, 1'b1);
    check("t4_pc0", acc_pc[0], 32'h40);
    check("t4_instr0", acc_instr[0], 16'h0200);
    check("t4_pc1", acc_pc[1], 32'h41);

`ifdef FETCH_IRQ_EN
    // Interrupt entry with head pc 0x22, then irq colliding with a redirect.
    lat = 1;
    for (int i = 0; i < 16; i++) mem[8'h80 + i] = 16'h0300 + 16'(i);
    out_ready = 1'b0;
    do_redirect("t5", 32'h22);
    run(4);
    irq_req = 1'b1;
    #1;
    check("t5_ack_early", irq_ack, 1'b0);
    cycle();
    irq_req = 1'b0;
    #1;
    check("t5_ack", irq_ack, 1'b1);
    check("t5_epc", irq_epc, 32'h22);
    check("t5_valid_low", out_valid, 1'b0);
    check("t5_req_low", imem_req, 1'b0);
    clear_logs();
    cycle();
    out_ready = 1'b1;
    #1;
    check("t5_ack_pulse", irq_ack, 1'b0);
    run(8);
    check("t5_pc0", acc_pc[0], 32'h80);
    check("t5_instr0", acc_instr[0], 16'h0300);
    irq_req = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h50;
    #1;
    check("t5b_ack_deferred", irq_ack, 1'b0);
    cycle();
    irq_req = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("t5b_ack", irq_ack, 1'b1);
    check("t5b_epc", irq_epc, 32'h50);
    clear_logs();
    cycle();
    run(8);
    check("t5b_pc0", acc_pc[0], 32'h80);
`else
    // Interrupt logic absent: requests are ignored.
    irq_req = 1'b1;
    #1;
    check("t5_noirq_ack", irq_ack, 1'b0);
    check("t5_noirq_epc", irq_epc, 32'h0);
    cycle();
    irq_req = 1'b0;
    #1;
    check("t5_noirq_ack2", irq_ack, 1'b0);
    run(2);
`endif

    // Reset mid-operation with a stalled, filling queue.
    lat = 3;
    out_ready = 1'b0;
    do_redirect("t6", 32'h20);
    run(5);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    pend.delete();
    cycle();
    for (int i = 0; i < 16; i++) mem[8'h10 + i] = 16'h0400 + 16'(i);
    lat = 1;
    out_ready = 1'b1;
    clear_logs();
    rst = 1'b1;
    run(10);
    check("t6_addr0", req_log[0], 32'h10);
    check("t6_nacc", acc_pc.size() >= 2, 1'b1);
    check("t6_pc0", acc_pc[0], 32'h10);
    check("t6_instr0", acc_instr[0], 16'h0400);
    check("t6_pc1", acc_pc[1], 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Parametrised instruction-fetch front end that replaces the single-slot fetch stage. It streams 16-bit instruction halfwords from instruction memory through a DEPTH-entry prefetch queue and fuses any opcode carrying an immediate with its following halfword. It hands decode one instruction per cycle under a valid/ready stall handshake, and handles jump redirects and interrupt entry by flushing the queue and discarding stale memory responses.

## Interface
- ADDR_W, 32, PC/address width; PC counts halfwords, +1 per halfword.
- INSTR_W, 16, instruction halfword width.
- DEPTH, 4, queue entries (power of two, ≥2).
- RESET_PC, 0, fetch address after reset.
- IRQ_VECTOR, 0, fetch address on interrupt entry.
- IMM_CLASS, 3'b001, value of instr[INSTR_W-1:INSTR_W-3] marking a two-halfword instruction.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request halfword address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  in-order response valid, latency ≥1.
- imem_rdata  in  INSTR_W  response halfword.
- redirect_valid  in  1  jump/branch taken.
- redirect_pc  in  ADDR_W  jump target.
- irq_req  in  1  interrupt request pulse.
- irq_ack  out  1  one-cycle pulse: interrupt taken.
- irq_epc  out  ADDR_W  return PC, valid with irq_ack.
- out_valid  out  1  instruction available.
- out_ready  in  1  decode accepts; low means stall.
- out_instr  out  INSTR_W  instruction halfword.
- out_imm  out  INSTR_W  immediate halfword; 0 when out_has_imm=0.
- out_has_imm  out  1  instruction is two halfwords.
- out_pc  out  ADDR_W  PC of out_instr.
- out_next_pc  out  ADDR_W  out_pc+1+out_has_imm.

## Operation
- Reset values: fetch_pc=RESET_PC; queue empty; outstanding=0, discard=0, irq_pending=0. All outputs 0 except out_next_pc=1.
- Request rule: imem_req=1 when outstanding+count<DEPTH and no redirect/irq entry happens this cycle; imem_addr=fetch_pc. A grant increments fetch_pc and outstanding.
- Response: each imem_rvalid decrements outstanding. If discard>0, the response is dropped and discard is decremented. Otherwise {rdata, pc} is pushed; the stored pc counts up from the queue base.
- Issue: the head is a plain halfword → out_valid when count≥1. The head matches IMM_CLASS → out_valid only when count≥2, out_imm=head+1. A pop of 1 or 2 entries happens on out_valid&&out_ready.
- Redirect (redirect_valid=1): queue flushed; discard+=outstanding (including any response arriving this cycle); fetch_pc=redirect_pc; out_valid forced 0; no request this cycle.
- Interrupt: irq_req sets irq_pending. Entry occurs on the first cycle with irq_pending=1 and redirect_valid=0, with these actions:
  - irq_ack=1, irq_epc=head pc (fetch_pc if the queue is empty).
  - Same flush/discard as a redirect, with fetch_pc=IRQ_VECTOR.
  - irq_pending cleared.
- Priority: redirect > interrupt entry > issue. A redirect coinciding with irq leaves irq pending for the next cycle.
- Grant and rvalid for the same count in one cycle: outstanding is unchanged.

## Timing
- Earliest issue: grant in cycle N → rvalid ≥N+1 → out_valid in the cycle after the push, with registered queue and show-ahead head.
- Steady state: 1 instruction/cycle with single-cycle memory and DEPTH≥2, except two-halfword instructions, which need 2 fetched halfwords.
- out_* hold stable while out_valid&&!out_ready.
- Redirect at cycle N: new request at N+1; no stale data is ever visible on out_*.
- Reset mid-operation: all state returns to reset values immediately; imem_req drops asynchronously.

## Configuration
- FETCH_IRQ_EN defined: interrupt logic present as described.
- FETCH_IRQ_EN undefined: irq_req is ignored, irq_ack ties to 0, irq_epc ties to 0, and irq_pending logic is removed.

## Structure
- The shared package fetch_pkg holds:
  - the ADDR_W/INSTR_W defaults,
  - the IMM_CLASS constant,
  - the function is_imm_instr(halfword),
  - a typedef for a queue entry {instr, pc}.
- Sub-module fetch_fifo: DEPTH-entry show-ahead FIFO with 0/1 push, 0/1/2 pop, synchronous flush, and count output.

## Test plan
- Reset with RESET_PC=0x10, 1-cycle memory returning 0x0001,0x0002: imem_addr sequence 0x10,0x11; out_instr 0x0001 @pc 0x10, then 0x0002 @pc 0x11.
- Memory 0x3811,0x0004 at pc 0: a single output with out_instr=0x3811, out_has_imm=1, out_imm=0x0004, out_next_pc=2.
- out_ready=0 for 6 cycles: out_* stay stable, imem_req deasserts once outstanding+count=4, and no halfword is lost after release.
- 3-cycle memory latency, redirect to 0x40 with 3 outstanding: those 3 responses are dropped and the first output has out_pc=0x40.
- irq_req while the head pc is 0x22: irq_ack with irq_epc=0x22, then fetching resumes at IRQ_VECTOR. With irq and redirect in the same cycle, the redirect is taken first and irq_ack follows one cycle later.
- rst asserted with the queue full and 2 outstanding: outputs go to reset values at once, and fetching restarts at RESET_PC with no stale output.
